// File: rtl/block_mem_responder.sv
// Block-wide memory responder for cache refill/write-back; fixed LATENCY edges from request sample to completion.
// Optional BLOCK_MEM_INIT_EN: reset loads every block i with word j = i*2**BLOCK_SIZE + j.
module block_mem_responder #(
    parameter int BLOCK_SIZE     = 2,
    parameter int LINE_SIZE      = 32,
    parameter int ADDRESS_SIZE   = 32,
    parameter int MEM_DEPTH_LOG2 = 8,
    parameter int LATENCY        = 4
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic                                   m_read_i,
    input  logic                                   m_wr_i,
    input  logic [ADDRESS_SIZE-BLOCK_SIZE-3:0]     m_addr_i,
    input  logic [(2**BLOCK_SIZE)*LINE_SIZE-1:0]   m_wr_data_i,
    output logic                                   m_busywait_o,
    output logic [(2**BLOCK_SIZE)*LINE_SIZE-1:0]   m_read_data_o,
    output logic                                   m_write_done_o,
    output logic                                   m_read_done_o
);

    localparam int BW    = (2**BLOCK_SIZE) * LINE_SIZE;
    localparam int AW    = ADDRESS_SIZE - BLOCK_SIZE - 2;
    localparam int DEPTH = 2**MEM_DEPTH_LOG2;
    localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                    state_q;
    logic                      is_wr_q;
    logic [MEM_DEPTH_LOG2-1:0] idx_q;
    logic [BW-1:0]             wdata_q;
    logic [CW-1:0]             cnt_q;
    logic                      busy_q;
    logic                      wdone_q;
    logic                      rdone_q;
    logic [BW-1:0]             rdata_q;
    logic [BW-1:0]             mem_q [DEPTH];
    logic                      mem_we_d;

    // Upper block-address bits alias onto the stored depth.
    generate
        if (AW > MEM_DEPTH_LOG2) begin : g_addr_hi
            logic addr_hi_unused;
            assign addr_hi_unused = ^m_addr_i[AW-1:MEM_DEPTH_LOG2];
        end
    endgenerate

    assign mem_we_d = (state_q == BUSY) && (cnt_q == '0) && is_wr_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            is_wr_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            wdone_q <= 1'b0;
            rdone_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Write wins a simultaneous request; the cache re-issues the read.
                    if (m_wr_i || m_read_i) begin
                        is_wr_q <= m_wr_i;
                        idx_q   <= m_addr_i[MEM_DEPTH_LOG2-1:0];
                        cnt_q   <= CW'(LATENCY - 1);
                        busy_q  <= 1'b1;
                        state_q <= BUSY;
                        if (m_wr_i) begin
                            wdata_q <= m_wr_data_i;
                        end
                    end
                end
                BUSY: begin
                    if (cnt_q == '0) begin
                        if (is_wr_q) begin
                            wdone_q <= 1'b1;
                        end else begin
                            rdone_q <= 1'b1;
                            rdata_q <= mem_q[idx_q];
                        end
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    wdone_q <= 1'b0;
                    rdone_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef BLOCK_MEM_INIT_EN
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int j = 0; j < 2**BLOCK_SIZE; j++) begin
                    mem_q[i][j*LINE_SIZE +: LINE_SIZE] <= LINE_SIZE'(i * (2**BLOCK_SIZE) + j);
                end
            end
        end else if (mem_we_d) begin
            mem_q[idx_q] <= wdata_q;
        end
    end
`else
    // Reset aborts an in-flight write but never clears stored blocks.
    always_ff @(posedge clk_i) begin
        if (mem_we_d && !reset_i) begin
            mem_q[idx_q] <= wdata_q;
        end
    end
`endif

    assign m_busywait_o   = busy_q;
    assign m_write_done_o = wdone_q;
    assign m_read_done_o  = rdone_q;
    assign m_read_data_o  = rdata_q;

endmodule
